// File: rtl/pc_ctrl_pkg.sv
// Shared types for the program-counter sequencer slice.
// PC mode encoding, address/operand widths and controller state.
package pc_ctrl_pkg;

   localparam int A = 8;
   localparam int N = 16;

   typedef enum logic [1:0] {
      HALTCOUNT = 2'd0,
      INCREMENT = 2'd1,
      ABSOLUTE  = 2'd2,
      RELATIVE  = 2'd3
   } modePC;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } pcCtrlState;

   function automatic logic [N-1:0] zext(input logic [A-1:0] v);
      return {{(N-A){1'b0}}, v};
   endfunction

endpackage

// File: rtl/pc_ctrl_ret_stack.sv
// Circular return-address stack: push on full overwrites the oldest
// entry, pop on empty yields 0; both raise a sticky error.
module ret_stack
   import pc_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         n_rst_i,
   input  logic         push,
   input  logic         pop,
   input  logic [A-1:0] wdata,
   output logic [A-1:0] data,
   output logic         full,
   output logic         empty,
   output logic         err
);

   localparam int PW = $clog2(DEPTH);

   logic [A-1:0] mem [DEPTH];
   logic [PW-1:0] wp;
   logic [PW:0]   cnt;

   assign full  = cnt == (PW+1)'(DEPTH);
   assign empty = cnt == '0;
   assign data  = empty ? '0 : mem[wp - PW'(1)];

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         wp  <= '0;
         cnt <= '0;
         err <= 1'b0;
      end else if (pop) begin
         if (empty) begin
            err <= 1'b1;
         end else begin
            wp  <= wp - PW'(1);
            cnt <= cnt - (PW+1)'(1);
         end
      end else if (push) begin
         wp <= wp + PW'(1);
         if (full) err <= 1'b1;
         else      cnt <= cnt + (PW+1)'(1);
      end
   end

   // Storage needs no reset: empty/count gate every read.
   always_ff @(posedge clk_i) begin
      if (push && !pop) mem[wp] <= wdata;
   end

endmodule

// File: rtl/pc_ctrl.sv
// PC sequencer: arbitrates halt/jump/branch/stall into pc mode and operand.
// Optional return stack enabled by PC_CTRL_CALLSTACK_EN.
module pc_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int STACK_DEPTH  = 4
) (
   input  logic                clk_i,
   input  logic                n_rst_i,
   input  logic [A-1:0]        addr_i,
   input  logic                stall_i,
   input  logic                rel_req_i,
   input  logic signed [N-1:0] rel_off_i,
   input  logic                abs_req_i,
   input  logic [N-1:0]        abs_tgt_i,
   input  logic                call_i,
   input  logic                ret_i,
   input  logic                halt_i,
   input  logic                resume_i,
   output modePC               mode_o,
   output logic signed [N-1:0] data_o,
   output logic                fetch_valid_o,
   output logic                halted_o,
   output logic                stack_err_o
);

   localparam int CW = $clog2(FLUSH_CYCLES + 1);

   pcCtrlState    state;
   logic [CW-1:0] flush_cnt;
   logic          run;
   logic          do_ret;
   logic [A-1:0]  pop_val;
   logic          redirect;

   assign run = (state == RUN) && !halt_i;

`ifdef PC_CTRL_CALLSTACK_EN
   logic do_push;
   logic unused_full;
   logic unused_empty;

   // ret outranks call, so a same-cycle call never pushes.
   assign do_ret  = run && ret_i;
   assign do_push = run && call_i && !ret_i;

   ret_stack #(
      .DEPTH(STACK_DEPTH)
   ) u_ret_stack (
      .clk_i  (clk_i),
      .n_rst_i(n_rst_i),
      .push   (do_push),
      .pop    (do_ret),
      .wdata  (addr_i + A'(1)),
      .data   (pop_val),
      .full   (unused_full),
      .empty  (unused_empty),
      .err    (stack_err_o)
   );
`else
   localparam int unused_depth = STACK_DEPTH;
   logic unused_sigs;

   assign unused_sigs = ret_i ^ (|addr_i);
   assign do_ret      = 1'b0;
   assign pop_val     = '0;
   assign stack_err_o = 1'b0;
`endif

   always_comb begin
      mode_o   = HALTCOUNT;
      data_o   = '0;
      redirect = 1'b0;
      if (state == RUN) begin
         priority case (1'b1)
            halt_i: mode_o = HALTCOUNT;
            do_ret: begin
               mode_o   = ABSOLUTE;
               data_o   = zext(pop_val);
               redirect = 1'b1;
            end
            call_i | abs_req_i: begin
               mode_o   = ABSOLUTE;
               data_o   = abs_tgt_i;
               redirect = 1'b1;
            end
            rel_req_i: begin
               mode_o   = RELATIVE;
               data_o   = rel_off_i;
               redirect = 1'b1;
            end
            stall_i: mode_o = HALTCOUNT;
            default: mode_o = INCREMENT;
         endcase
      end else if (state == HALTED && resume_i) begin
         mode_o = INCREMENT;
      end
   end

   assign fetch_valid_o = run && flush_cnt == '0 && !stall_i;
   assign halted_o      = state == HALTED;

   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         state     <= BOOT;
         flush_cnt <= '0;
      end else begin
         unique case (state)
            BOOT:    state <= RUN;
            RUN:     if (halt_i) state <= HALTED;
            HALTED:  if (resume_i) state <= RUN;
            default: state <= BOOT;
         endcase
         if (redirect)
            flush_cnt <= CW'(FLUSH_CYCLES);
         else if (flush_cnt != '0 && !stall_i)
            flush_cnt <= flush_cnt - CW'(1);
      end
   end

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed bench for pc_ctrl with a behavioural pc closing the loop.
// Stack checks follow PC_CTRL_CALLSTACK_EN.
module tb_pc_ctrl;
   import pc_ctrl_pkg::*;

   localparam int FL = 2;

   logic clk = 1'b0;
   logic n_rst = 1'b0;
   logic [A-1:0] pc;
   logic stall, rel, abs, call, ret, halt, resume;
   logic signed [N-1:0] off;
   logic [N-1:0] tgt;
   modePC mode;
   logic signed [N-1:0] data;
   logic fv, halted, serr;

   int vec = 0;
   int errs = 0;

   always #5 clk = ~clk;

   pc_ctrl #(
      .FLUSH_CYCLES(FL),
      .STACK_DEPTH (4)
   ) dut (
      .clk_i        (clk),
      .n_rst_i      (n_rst),
      .addr_i       (pc),
      .stall_i      (stall),
      .rel_req_i    (rel),
      .rel_off_i    (off),
      .abs_req_i    (abs),
      .abs_tgt_i    (tgt),
      .call_i       (call),
      .ret_i        (ret),
      .halt_i       (halt),
      .resume_i     (resume),
      .mode_o       (mode),
      .data_o       (data),
      .fetch_valid_o(fv),
      .halted_o     (halted),
      .stack_err_o  (serr)
   );

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) pc <= '0;
      else begin
         case (mode)
            INCREMENT: pc <= pc + A'(1);
            ABSOLUTE:  pc <= data[A-1:0];
            RELATIVE:  pc <= pc + data[A-1:0];
            default:   pc <= pc;
         endcase
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle();
      stall = 0; rel = 0; abs = 0; call = 0;
      ret = 0; halt = 0; resume = 0;
      off = '0; tgt = '0;
   endtask

   task automatic test_reset();
      idle();
      n_rst = 0;
      nxt(); smp();
      vec++;
      if (mode !== HALTCOUNT || fv !== 1'b0 || halted !== 1'b0 || serr !== 1'b0) begin
         errs++;
         $display("FAIL reset_outs: mode=%0d fv=%b halted=%b err=%b want 0 0 0 0", mode, fv, halted, serr);
      end
      nxt();
      n_rst = 1;
      smp();
      vec++;
      if (mode !== HALTCOUNT || fv !== 1'b0 || pc !== 8'd0) begin
         errs++;
         $display("FAIL boot_cycle: mode=%0d fv=%b pc=%0d want 0 0 0", mode, fv, pc);
      end
      for (int i = 0; i < 4; i++) begin
         nxt(); smp();
         vec++;
         if (mode !== INCREMENT || fv !== 1'b1 || pc !== A'(i)) begin
            errs++;
            $display("FAIL run_inc%0d: mode=%0d fv=%b pc=%0d want 1 1 %0d", i, mode, fv, pc, i);
         end
      end
      nxt();
   endtask

   task automatic test_rel_branch();
      abs = 1; tgt = N'(10 - FL);
      smp();
      vec++;
      if (mode !== ABSOLUTE || data !== N'(10 - FL) || fv !== 1'b1) begin
         errs++;
         $display("FAIL abs_setup: mode=%0d data=%0d fv=%b want 2 %0d 1", mode, data, fv, 10 - FL);
      end
      nxt(); idle();
      for (int i = 0; i < FL; i++) begin
         smp();
         vec++;
         if (fv !== 1'b0 || pc !== A'(10 - FL + i)) begin
            errs++;
            $display("FAIL abs_flush%0d: fv=%b pc=%0d want 0 %0d", i, fv, pc, 10 - FL + i);
         end
         nxt();
      end
      rel = 1; off = -16'sd4;
      smp();
      vec++;
      if (mode !== RELATIVE || data !== -16'sd4 || fv !== 1'b1 || pc !== 8'd10) begin
         errs++;
         $display("FAIL rel_issue: mode=%0d data=%0d fv=%b pc=%0d want 3 -4 1 10", mode, data, fv, pc);
      end
      nxt(); idle();
      for (int i = 0; i < FL; i++) begin
         smp();
         vec++;
         if (fv !== 1'b0 || pc !== A'(6 + i)) begin
            errs++;
            $display("FAIL rel_flush%0d: fv=%b pc=%0d want 0 %0d", i, fv, pc, 6 + i);
         end
         nxt();
      end
      smp();
      vec++;
      if (fv !== 1'b1 || pc !== A'(6 + FL)) begin
         errs++;
         $display("FAIL rel_after: fv=%b pc=%0d want 1 %0d", fv, pc, 6 + FL);
      end
      nxt();
   endtask

   task automatic test_halt();
      halt = 1; abs = 1; tgt = 16'h20;
      smp();
      vec++;
      if (mode !== HALTCOUNT || data !== 16'sd0 || fv !== 1'b0 || halted !== 1'b0) begin
         errs++;
         $display("FAIL halt_issue: mode=%0d data=%0d fv=%b halted=%b want 0 0 0 0", mode, data, fv, halted);
      end
      nxt(); idle();
      abs = 1; rel = 1; off = 16'sd3; tgt = 16'h30;
      smp();
      vec++;
      if (mode !== HALTCOUNT || halted !== 1'b1 || fv !== 1'b0 || pc !== A'(7 + FL)) begin
         errs++;
         $display("FAIL halted_ign: mode=%0d halted=%b fv=%b pc=%0d want 0 1 0 %0d", mode, halted, fv, pc, 7 + FL);
      end
      nxt(); idle();
      resume = 1;
      smp();
      vec++;
      if (mode !== INCREMENT || halted !== 1'b1 || fv !== 1'b0 || pc !== A'(7 + FL)) begin
         errs++;
         $display("FAIL resume: mode=%0d halted=%b fv=%b pc=%0d want 1 1 0 %0d", mode, halted, fv, pc, 7 + FL);
      end
      nxt(); idle();
      smp();
      vec++;
      if (halted !== 1'b0 || fv !== 1'b1 || pc !== A'(8 + FL)) begin
         errs++;
         $display("FAIL resumed: halted=%b fv=%b pc=%0d want 0 1 %0d", halted, fv, pc, 8 + FL);
      end
      nxt();
   endtask

   task automatic test_stall();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         smp();
         vec++;
         if (mode !== HALTCOUNT || fv !== 1'b0 || pc !== A'(9 + FL)) begin
            errs++;
            $display("FAIL stall%0d: mode=%0d fv=%b pc=%0d want 0 0 %0d", i, mode, fv, pc, 9 + FL);
         end
         nxt();
      end
      stall = 0;
      smp();
      vec++;
      if (mode !== INCREMENT || fv !== 1'b1 || pc !== A'(9 + FL)) begin
         errs++;
         $display("FAIL unstall: mode=%0d fv=%b pc=%0d want 1 1 %0d", mode, fv, pc, 9 + FL);
      end
      nxt();
   endtask

   task automatic test_callstack();
      logic [A-1:0] pops [5];
      logic [A-1:0] first_pc;
      pops = '{8'h41, 8'h31, 8'h21, 8'h11, 8'h00};
      abs = 1; tgt = N'(5 - FL);
      nxt(); idle();
      repeat (FL) nxt();
      call = 1; tgt = 16'h40;
      smp();
      vec++;
      if (mode !== ABSOLUTE || data !== 16'sh40 || pc !== 8'd5) begin
         errs++;
         $display("FAIL call1: mode=%0d data=%0d pc=%0d want 2 64 5", mode, data, pc);
      end
      nxt(); idle();
      ret = 1;
      smp();
`ifdef PC_CTRL_CALLSTACK_EN
      first_pc = 8'd6;
      vec++;
      if (mode !== ABSOLUTE || data !== 16'sd6 || serr !== 1'b0) begin
         errs++;
         $display("FAIL ret1: mode=%0d data=%0d err=%b want 2 6 0", mode, data, serr);
      end
`else
      first_pc = 8'h41;
      vec++;
      if (mode !== INCREMENT || data !== 16'sd0 || serr !== 1'b0) begin
         errs++;
         $display("FAIL ret_ignored: mode=%0d data=%0d err=%b want 1 0 0", mode, data, serr);
      end
`endif
      nxt(); idle();
      for (int i = 0; i < 5; i++) begin
         call = 1; tgt = N'(16 * (i + 1));
         smp();
         vec++;
         if (mode !== ABSOLUTE || data !== N'(16 * (i + 1)) || pc !== (i == 0 ? first_pc : A'(16 * i))) begin
            errs++;
            $display("FAIL calls%0d: mode=%0d data=%0d pc=%0d want 2 %0d", i, mode, data, pc, 16 * (i + 1));
         end
         nxt();
      end
      idle();
      for (int i = 0; i < 5; i++) begin
         ret = 1;
         smp();
`ifdef PC_CTRL_CALLSTACK_EN
         vec++;
         if (mode !== ABSOLUTE || data !== zext(pops[i]) || serr !== 1'b1) begin
            errs++;
            $display("FAIL rets%0d: mode=%0d data=%0d err=%b want 2 %0d 1", i, mode, data, serr, pops[i]);
         end
`else
         vec++;
         if (mode !== INCREMENT || serr !== 1'b0) begin
            errs++;
            $display("FAIL rets%0d: mode=%0d err=%b want 1 0", i, mode, serr);
         end
`endif
         nxt();
      end
      idle();
      repeat (FL) nxt();
   endtask

   task automatic test_flush_reload();
      abs = 1; tgt = 16'h60;
      smp();
      vec++;
      if (fv !== 1'b1) begin
         errs++;
         $display("FAIL reload_pre: fv=%b want 1", fv);
      end
      nxt(); idle();
      nxt();
      rel = 1; off = 16'sd3;
      smp();
      vec++;
      if (mode !== RELATIVE || fv !== 1'b0 || pc !== 8'h61) begin
         errs++;
         $display("FAIL reload_issue: mode=%0d fv=%b pc=%0d want 3 0 97", mode, fv, pc);
      end
      nxt(); idle();
      for (int i = 0; i < FL; i++) begin
         smp();
         vec++;
         if (fv !== 1'b0 || pc !== A'(8'h64 + i)) begin
            errs++;
            $display("FAIL reload_flush%0d: fv=%b pc=%0d want 0 %0d", i, fv, pc, 8'h64 + i);
         end
         nxt();
      end
      smp();
      vec++;
      if (fv !== 1'b1) begin
         errs++;
         $display("FAIL reload_done: fv=%b want 1", fv);
      end
      nxt();
   endtask

   task automatic test_stall_redirect();
      stall = 1; abs = 1; tgt = 16'h30;
      smp();
      vec++;
      if (mode !== ABSOLUTE || data !== 16'sh30 || fv !== 1'b0) begin
         errs++;
         $display("FAIL stall_jump: mode=%0d data=%0d fv=%b want 2 48 0", mode, data, fv);
      end
      nxt();
      abs = 0;
      repeat (2) begin
         smp();
         vec++;
         if (mode !== HALTCOUNT || fv !== 1'b0 || pc !== 8'h30) begin
            errs++;
            $display("FAIL stall_hold: mode=%0d fv=%b pc=%0d want 0 0 48", mode, fv, pc);
         end
         nxt();
      end
      stall = 0;
      for (int i = 0; i < FL; i++) begin
         smp();
         vec++;
         if (fv !== 1'b0) begin
            errs++;
            $display("FAIL stall_flush%0d: fv=%b want 0", i, fv);
         end
         nxt();
      end
      smp();
      vec++;
      if (fv !== 1'b1) begin
         errs++;
         $display("FAIL stall_done: fv=%b want 1", fv);
      end
      nxt();
   endtask

   task automatic test_reset_mid();
      abs = 1; tgt = 16'h70;
      nxt(); idle();
      n_rst = 0;
      smp();
      vec++;
      if (mode !== HALTCOUNT || fv !== 1'b0 || pc !== 8'd0 || serr !== 1'b0) begin
         errs++;
         $display("FAIL mid_reset: mode=%0d fv=%b pc=%0d err=%b want 0 0 0 0", mode, fv, pc, serr);
      end
      nxt();
      n_rst = 1;
      smp();
      vec++;
      if (mode !== HALTCOUNT || fv !== 1'b0) begin
         errs++;
         $display("FAIL mid_boot: mode=%0d fv=%b want 0 0", mode, fv);
      end
      nxt(); smp();
      vec++;
      if (mode !== INCREMENT || fv !== 1'b1 || pc !== 8'd0) begin
         errs++;
         $display("FAIL mid_run: mode=%0d fv=%b pc=%0d want 1 1 0", mode, fv, pc);
      end
      nxt();
   endtask

   initial begin
      idle();
      test_reset();
      test_rel_branch();
      test_halt();
      test_stall();
      test_callstack();
      test_flush_reload();
      test_stall_redirect();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
